// File: rtl/stdp_array.sv
// STDP learning engine: sweeps an N_PRE x N_POST signed Q8.8 weight array once per timestep strobe.
// Optional STDP_FREEZE_EN adds a FREEZE input that suppresses weight writes while sweeps continue.
module stdp_array #(
  parameter int N_PRE = 16,
  parameter int N_POST = 4,
  parameter int W_BITS = 16,
  parameter int PRE_WIN = 16,
  parameter int POST_WIN = 6,
  parameter logic signed [W_BITS-1:0] W_MAX = 16'sd7680,
  parameter logic signed [W_BITS-1:0] W_MIN = -16'sd2560,
  parameter int LTP_STEP = 256,
  parameter int LTD_STEP = 256,
  parameter logic signed [W_BITS-1:0] W_INIT = '0,
  localparam int S = N_PRE * N_POST,
  localparam int AW = $clog2(S)
) (
  input  logic              CLK,
  input  logic              RST,
  input  logic              EN,
  input  logic [N_PRE-1:0]  PRE_SPIKES,
  input  logic [N_POST-1:0] POST_SPIKES,
`ifdef STDP_FREEZE_EN
  input  logic              FREEZE,
`endif
  input  logic [AW-1:0]     RD_ADDR,
  output logic [W_BITS-1:0] RD_DATA,
  output logic              BUSY,
  output logic              DONE,
  output logic              WE,
  output logic [AW-1:0]     ADDR,
  output logic [W_BITS-1:0] WDATA,
  output logic              OVERRUN
);

  localparam int JW = $clog2(N_PRE);
  localparam int KW = (N_POST > 1) ? $clog2(N_POST) : 1;

  // BUSY is the state bit itself, so the FSM state is directly observable.
  localparam logic [0:0] IDLE  = 1'b0;
  localparam logic [0:0] SWEEP = 1'b1;

  localparam logic [1:0] MODE_NONE = 2'd0;
  localparam logic [1:0] MODE_LTP  = 2'd1;
  localparam logic [1:0] MODE_LTD  = 2'd2;

  localparam logic [7:0] PRE_WIN_C  = 8'(PRE_WIN);
  localparam logic [7:0] POST_WIN_C = 8'(POST_WIN);

  localparam logic signed [W_BITS:0] WMAX_EXT = {W_MAX[W_BITS-1], W_MAX};
  localparam logic signed [W_BITS:0] WMIN_EXT = {W_MIN[W_BITS-1], W_MIN};
  localparam logic signed [W_BITS:0] LTP_EXT  = (W_BITS+1)'(LTP_STEP);
  localparam logic signed [W_BITS:0] LTD_EXT  = (W_BITS+1)'(LTD_STEP);

  logic [0:0]        state_q, state_d;
  logic [AW-1:0]     idx_q, idx_d;
  logic [JW-1:0]     j_q, j_d;
  logic [KW-1:0]     k_q, k_d;
  logic [N_PRE-1:0]  pre_lat_q, pre_lat_d;
  logic [N_POST-1:0] post_lat_q, post_lat_d;
  logic [7:0]        pre_cnt_q [N_PRE];
  logic [7:0]        pre_cnt_d [N_PRE];
  logic [7:0]        post_cnt_q [N_POST];
  logic [7:0]        post_cnt_d [N_POST];
  logic [1:0]        mode_q [S];
  logic [1:0]        mode_d [S];
  logic [W_BITS-1:0] w_q [S];
  logic [W_BITS-1:0] w_d [S];
  logic              we_q, we_d;
  logic [AW-1:0]     addr_q, addr_d;
  logic [W_BITS-1:0] wdata_q, wdata_d;
  logic              done_q, done_d;
  logic              ovr_q, ovr_d;

  logic              freeze;
  logic [1:0]        mode_new;
  logic              fire;
  logic signed [W_BITS:0] cur_ext, sum_ext;
  logic [W_BITS-1:0] w_new;

`ifdef STDP_FREEZE_EN
  assign freeze = FREEZE;
`else
  assign freeze = 1'b0;
`endif

  always_comb begin
    state_d    = state_q;
    idx_d      = idx_q;
    j_d        = j_q;
    k_d        = k_q;
    pre_lat_d  = pre_lat_q;
    post_lat_d = post_lat_q;
    pre_cnt_d  = pre_cnt_q;
    post_cnt_d = post_cnt_q;
    mode_d     = mode_q;
    w_d        = w_q;
    we_d       = 1'b0;
    addr_d     = addr_q;
    wdata_d    = wdata_q;
    done_d     = 1'b0;
    ovr_d      = ovr_q;
    mode_new   = mode_q[idx_q];
    fire       = 1'b0;
    cur_ext    = {w_q[idx_q][W_BITS-1], w_q[idx_q]};
    sum_ext    = cur_ext;
    w_new      = w_q[idx_q];

    case (state_q)
      IDLE: begin
        if (EN) begin
          state_d    = SWEEP;
          idx_d      = '0;
          j_d        = '0;
          k_d        = '0;
          pre_lat_d  = PRE_SPIKES;
          post_lat_d = POST_SPIKES;
          for (int n = 0; n < N_PRE; n++) begin
            pre_cnt_d[n] = PRE_SPIKES[n] ? PRE_WIN_C :
                           ((pre_cnt_q[n] != 8'd0) ? pre_cnt_q[n] - 8'd1 : 8'd0);
          end
          for (int n = 0; n < N_POST; n++) begin
            post_cnt_d[n] = POST_SPIKES[n] ? POST_WIN_C :
                            ((post_cnt_q[n] != 8'd0) ? post_cnt_q[n] - 8'd1 : 8'd0);
          end
        end
      end
      default: begin
        if (EN) ovr_d = 1'b1;
        // Pre spike wins over post spike; with neither, the synapse keeps its mode.
        if (pre_lat_q[j_q])       mode_new = MODE_LTD;
        else if (post_lat_q[k_q]) mode_new = MODE_LTP;
        mode_d[idx_q] = mode_new;

        fire = (pre_cnt_q[j_q] != 8'd0) && (post_cnt_q[k_q] != 8'd0) &&
               (mode_new != MODE_NONE);
        if (mode_new == MODE_LTP) begin
          sum_ext = cur_ext + LTP_EXT;
          w_new   = (sum_ext > WMAX_EXT) ? W_MAX : sum_ext[W_BITS-1:0];
        end else begin
          sum_ext = cur_ext - LTD_EXT;
          w_new   = (sum_ext < WMIN_EXT) ? W_MIN : sum_ext[W_BITS-1:0];
        end

        if (fire && !freeze) begin
          w_d[idx_q] = w_new;
          we_d       = 1'b1;
          addr_d     = idx_q;
          wdata_d    = w_new;
        end

        if (idx_q == AW'(S - 1)) begin
          state_d = IDLE;
          done_d  = 1'b1;
        end else begin
          idx_d = idx_q + 1'b1;
          if (j_q == JW'(N_PRE - 1)) begin
            j_d = '0;
            k_d = k_q + 1'b1;
          end else begin
            j_d = j_q + 1'b1;
          end
        end
      end
    endcase
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      state_q    <= IDLE;
      idx_q      <= '0;
      j_q        <= '0;
      k_q        <= '0;
      pre_lat_q  <= '0;
      post_lat_q <= '0;
      for (int n = 0; n < N_PRE; n++)  pre_cnt_q[n]  <= 8'd0;
      for (int n = 0; n < N_POST; n++) post_cnt_q[n] <= 8'd0;
      for (int n = 0; n < S; n++) begin
        mode_q[n] <= MODE_NONE;
        w_q[n]    <= W_INIT;
      end
      we_q    <= 1'b0;
      addr_q  <= '0;
      wdata_q <= '0;
      done_q  <= 1'b0;
      ovr_q   <= 1'b0;
    end else begin
      state_q    <= state_d;
      idx_q      <= idx_d;
      j_q        <= j_d;
      k_q        <= k_d;
      pre_lat_q  <= pre_lat_d;
      post_lat_q <= post_lat_d;
      pre_cnt_q  <= pre_cnt_d;
      post_cnt_q <= post_cnt_d;
      mode_q     <= mode_d;
      w_q        <= w_d;
      we_q       <= we_d;
      addr_q     <= addr_d;
      wdata_q    <= wdata_d;
      done_q     <= done_d;
      ovr_q      <= ovr_d;
    end
  end

  assign RD_DATA = w_q[RD_ADDR];
  assign BUSY    = (state_q == SWEEP);
  assign DONE    = done_q;
  assign WE      = we_q;
  assign ADDR    = addr_q;
  assign WDATA   = wdata_q;
  assign OVERRUN = ovr_q;

endmodule

// File: tb/tb_stdp_array.sv
// Directed bench for stdp_array: expected writes go into a queue, a negedge monitor checks every WE.
// Build with STDP_FREEZE_EN defined to also exercise the FREEZE input.
module tb_stdp_array;
  localparam int S  = 64;
  localparam int AW = 6;
  localparam int W  = 16;

  logic          CLK;
  logic          RST;
  logic          EN;
  logic [15:0]   PRE_SPIKES;
  logic [3:0]    POST_SPIKES;
  logic [AW-1:0] RD_ADDR;
  logic [W-1:0]  RD_DATA;
  logic          BUSY;
  logic          DONE;
  logic          WE;
  logic [AW-1:0] ADDR;
  logic [W-1:0]  WDATA;
  logic          OVERRUN;
`ifdef STDP_FREEZE_EN
  logic          FREEZE;
`endif

  int checks;
  int errors;
  logic [AW+W-1:0] exp_q[$];

  stdp_array dut (
    .CLK(CLK),
    .RST(RST),
    .EN(EN),
    .PRE_SPIKES(PRE_SPIKES),
    .POST_SPIKES(POST_SPIKES),
`ifdef STDP_FREEZE_EN
    .FREEZE(FREEZE),
`endif
    .RD_ADDR(RD_ADDR),
    .RD_DATA(RD_DATA),
    .BUSY(BUSY),
    .DONE(DONE),
    .WE(WE),
    .ADDR(ADDR),
    .WDATA(WDATA),
    .OVERRUN(OVERRUN)
  );

  // clock / reset
  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  task automatic do_reset();
    @(posedge CLK); #1;
    RST = 1'b1;
    repeat (2) @(posedge CLK);
    #1;
    RST = 1'b0;
    exp_q.delete();
  endtask

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] want);
    checks++;
    if (got !== want) begin
      errors++;
      $display("FAIL %s: got %0h, expected %0h", name, got, want);
    end
  endtask

  task automatic push(input int a, input int d);
    logic [AW-1:0] av;
    logic [W-1:0]  dv;
    av = a[AW-1:0];
    dv = d[W-1:0];
    exp_q.push_back({av, dv});
  endtask

  // one timestep: EN pulse with the given spikes, then wait for DONE
  task automatic step(input logic [15:0] pre, input logic [3:0] post);
    int  n;
    bit  seen;
    @(posedge CLK); #1;
    EN = 1'b1;
    PRE_SPIKES = pre;
    POST_SPIKES = post;
    @(posedge CLK); #1;
    EN = 1'b0;
    PRE_SPIKES = '0;
    POST_SPIKES = '0;
    n = 0;
    seen = 1'b0;
    while (!seen && n < 200) begin
      @(negedge CLK);
      n++;
      if (DONE) seen = 1'b1;
    end
    check("done_latency", n, 65);
  endtask

  task automatic read_check(input string name, input int a, input logic [W-1:0] want);
    RD_ADDR = a[AW-1:0];
    #1;
    check(name, RD_DATA, want);
  endtask

  // scoreboard monitor
  always @(negedge CLK) begin
    if (!RST && WE) begin
      checks++;
      if (exp_q.size() == 0) begin
        errors++;
        $display("FAIL unexpected_write: addr %0d data %0h, expected no write", ADDR, WDATA);
      end else begin
        logic [AW+W-1:0] e;
        e = exp_q.pop_front();
        if ({ADDR, WDATA} !== e) begin
          errors++;
          $display("FAIL write: addr %0d data %0h, expected addr %0d data %0h",
                   ADDR, WDATA, e[AW+W-1:W], e[W-1:0]);
        end
      end
    end
  end

  initial begin
    int w;
    checks = 0;
    errors = 0;
    RST = 1'b1;
    EN = 1'b0;
    PRE_SPIKES = '0;
    POST_SPIKES = '0;
    RD_ADDR = '0;
`ifdef STDP_FREEZE_EN
    FREEZE = 1'b0;
`endif
    do_reset();

    @(negedge CLK);
    check("reset_busy", BUSY, 0);
    check("reset_done", DONE, 0);
    check("reset_we", WE, 0);
    check("reset_overrun", OVERRUN, 0);
    check("reset_addr", ADDR, 0);
    check("reset_wdata", WDATA, 0);
    read_check("reset_rd0", 0, 16'h0000);

    // pre j=0 at step 1, post k=0 at step 3: LTP on synapse 0 only
    push(0, 256);
    step(16'h0001, 4'h0);
    step(16'h0000, 4'h0);
    step(16'h0000, 4'h1);
    check("ltp_queue_drained", exp_q.size(), 0);
    read_check("ltp_rd0", 0, 16'h0100);
    read_check("ltp_rd1", 1, 16'h0000);
    read_check("ltp_rd16", 16, 16'h0000);

    // post k=1 at step 1, pre j=2 at step 2: LTD on synapse 18
    do_reset();
    push(18, -256);
    step(16'h0000, 4'h2);
    step(16'h0004, 4'h0);
    check("ltd_queue_drained", exp_q.size(), 0);
    read_check("ltd_rd18", 18, 16'hFF00);
    read_check("ltd_rd2", 2, 16'h0000);

    // repeated LTP on synapse 0, refreshing the pre window every 16 steps
    do_reset();
    w = 0;
    for (int r = 0; r < 3; r++) begin
      if (r > 0) begin
        w = (w - 256 < -2560) ? -2560 : w - 256;
        push(0, w);
      end
      step(16'h0001, 4'h0);
      for (int p = 0; p < 15; p++) begin
        w = (w + 256 > 7680) ? 7680 : w + 256;
        push(0, w);
        step(16'h0000, 4'h1);
      end
    end
    check("sat_queue_drained", exp_q.size(), 0);
    read_check("sat_rd0", 0, 16'h1E00);

    // pre at step 1, post at step 18: pre window expired, no write
    do_reset();
    step(16'h0001, 4'h0);
    for (int p = 0; p < 16; p++) step(16'h0000, 4'h0);
    step(16'h0000, 4'h1);
    read_check("late_post_rd0", 0, 16'h0000);

    // overrun then mid-sweep reset
    do_reset();
    push(0, 256);
    step(16'h0001, 4'h0);
    step(16'h0000, 4'h1);
    push(0, 512);
    RD_ADDR = '0;
    @(posedge CLK); #1;
    EN = 1'b1;
    @(posedge CLK); #1;
    EN = 1'b0;
    repeat (9) @(posedge CLK);
    #1;
    EN = 1'b1;
    @(posedge CLK); #1;
    EN = 1'b0;
    @(negedge CLK);
    check("overrun_set", OVERRUN, 1);
    check("overrun_busy", BUSY, 1);
    repeat (8) @(posedge CLK);
    @(negedge CLK);
    check("pre_reset_rd0", RD_DATA, 16'h0200);
    check("pre_reset_queue", exp_q.size(), 0);
    @(posedge CLK); #1;
    RST = 1'b1;
    @(posedge CLK); #1;
    RST = 1'b0;
    @(negedge CLK);
    check("abort_busy", BUSY, 0);
    check("abort_overrun", OVERRUN, 0);
    check("abort_done", DONE, 0);
    for (int a = 0; a < S; a++) read_check("abort_rd", a, 16'h0000);

`ifdef STDP_FREEZE_EN
    // frozen: same spikes as the first scenario, sweeps complete but nothing is written
    do_reset();
    FREEZE = 1'b1;
    step(16'h0001, 4'h0);
    step(16'h0000, 4'h0);
    step(16'h0000, 4'h1);
    FREEZE = 1'b0;
    read_check("freeze_rd0", 0, 16'h0000);
`endif

    repeat (3) @(posedge CLK);
    check("final_queue_empty", exp_q.size(), 0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL timeout: simulation exceeded time limit");
    $fatal(1);
  end

endmodule
